// File: rtl/stats_epoch_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stats_epoch_sched_pkg
// Description : Shared definitions for the statistics epoch scheduler.
//               Contents:
//                 - state_e     : report FSM state encoding
//                 - c_epoch_w   : width of the epoch counter (28 bits)
//                 - c_hdr_idx   : record index used for the header record
// Revision    : 1.0 - initial release
// ============================================================================
package stats_epoch_sched_pkg;

    localparam int unsigned c_epoch_w = 28;
    localparam logic [7:0]  c_hdr_idx = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2
    } state_e;

endpackage : stats_epoch_sched_pkg
`default_nettype wire

// File: rtl/stats_epoch_sched_timer.sv
`default_nettype none
// ============================================================================
// Module      : stats_epoch_timer
// Description : Free-running epoch counter. Counts 0..EPOCH_TICKS while
//               sched_en is high, holds while low, and flags the terminal
//               count on epoch_tick.
// Ports       : asclk      in   clock
//               aresetn    in   asynchronous active-low reset
//               sched_en   in   counting enable
//               cnt_time   out  current epoch count (28 bits)
//               epoch_tick out  high while cnt_time == EPOCH_TICKS
// Revision    : 1.0 - initial release
// ============================================================================
module stats_epoch_timer
    import stats_epoch_sched_pkg::*;
#(
    parameter int unsigned EPOCH_TICKS = 160000000
) (
    input  logic                 asclk,
    input  logic                 aresetn,
    input  logic                 sched_en,
    output logic [c_epoch_w-1:0] cnt_time,
    output logic                 epoch_tick
);

    localparam logic [c_epoch_w-1:0] c_term = c_epoch_w'(EPOCH_TICKS);

    logic [c_epoch_w-1:0] cnt_q;
    logic [c_epoch_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sched_en) begin
            cnt_d = (cnt_q == c_term) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_time   = cnt_q;
    assign epoch_tick = (cnt_q == c_term);

endmodule : stats_epoch_timer
`default_nettype wire

// File: rtl/stats_epoch_sched.sv
`default_nettype none
// ============================================================================
// Module      : stats_epoch_sched
// Description : Epoch scheduler. Broadcasts the epoch counter, snapshots the
//               feature counters one cycle after each epoch tick and streams
//               them out as one 32-bit record per feature. A report still in
//               flight when the next tick arrives is aborted and counted.
// Ports       : asclk/aresetn      clock / asynchronous active-low reset
//               sched_en           epoch counting enable
//               feat_val           NUM_FEAT x 32-bit feature snapshots
//               cnt_time           epoch counter (28 bits)
//               epoch_tick         terminal-count flag
//               rpt_valid/ready    report stream handshake
//               rpt_data/idx/last  record payload, index, end-of-report
//               overrun_cnt        saturating aborted-report counter
//               busy               FSM not idle
// Options     : STATS_SCHED_SEQNUM_EN - prefix each report with a header
//               record (idx 0xFF) carrying a 32-bit epoch sequence number.
// Revision    : 1.0 - initial release
// ============================================================================
module stats_epoch_sched
    import stats_epoch_sched_pkg::*;
#(
    parameter int unsigned EPOCH_TICKS = 160000000,
    parameter int unsigned NUM_FEAT    = 4
) (
    input  logic                     asclk,
    input  logic                     aresetn,
    input  logic                     sched_en,
    input  logic [NUM_FEAT*32-1:0]   feat_val,
    output logic [c_epoch_w-1:0]     cnt_time,
    output logic                     epoch_tick,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [31:0]              rpt_data,
    output logic [7:0]               rpt_idx,
    output logic                     rpt_last,
    output logic [15:0]              overrun_cnt,
    output logic                     busy
);

    localparam logic [7:0] c_last_ptr = 8'(NUM_FEAT - 1);

    // ------------------------------------------------------------------
    // Epoch counter
    // ------------------------------------------------------------------
    stats_epoch_timer #(
        .EPOCH_TICKS (EPOCH_TICKS)
    ) u_timer (
        .asclk      (asclk),
        .aresetn    (aresetn),
        .sched_en   (sched_en),
        .cnt_time   (cnt_time),
        .epoch_tick (epoch_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [7:0]             ptr_q,       ptr_d;
    logic [NUM_FEAT*32-1:0] snap_q,      snap_d;
    logic [15:0]            ovr_q,       ovr_d;
    logic                   rpt_valid_q, rpt_valid_d;
    logic [31:0]            rpt_data_q,  rpt_data_d;
    logic [7:0]             rpt_idx_q,   rpt_idx_d;
    logic                   rpt_last_q,  rpt_last_d;
    logic                   busy_q,      busy_d;
`ifdef STATS_SCHED_SEQNUM_EN
    logic [31:0]            seq_q,       seq_d;
    logic                   hdr_q,       hdr_d;   // header record pending
`endif

    logic        w_hs;
    logic [31:0] w_rec_data;

    assign w_hs = rpt_valid_q & rpt_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        snap_d     = snap_q;
        ovr_d      = ovr_q;
`ifdef STATS_SCHED_SEQNUM_EN
        seq_d      = seq_q;
        hdr_d      = hdr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (epoch_tick) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                snap_d  = feat_val;
                ptr_d   = '0;
                state_d = ST_SEND;
`ifdef STATS_SCHED_SEQNUM_EN
                seq_d   = seq_q + 32'd1;
                hdr_d   = 1'b1;
`endif
            end

            ST_SEND: begin
                // A tick only aborts when it does not coincide with the
                // final handshake; rpt_last_q is the record being offered.
                if (epoch_tick && !(w_hs && rpt_last_q)) begin
                    state_d = ST_CAPTURE;
                    if (ovr_q != 16'hFFFF) begin
                        ovr_d = ovr_q + 16'd1;
                    end
                end else if (w_hs) begin
`ifdef STATS_SCHED_SEQNUM_EN
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                    end else
`endif
                    if (rpt_last_q) begin
                        state_d = epoch_tick ? ST_CAPTURE : ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered: decode them from the next-state values.
        w_rec_data = '0;
        for (int i = 0; i < int'(NUM_FEAT); i++) begin
            if (ptr_d == 8'(i)) begin
                w_rec_data = snap_d[32*i +: 32];
            end
        end

        rpt_valid_d = (state_d == ST_SEND);
        rpt_data_d  = rpt_valid_d ? w_rec_data : '0;
        rpt_idx_d   = rpt_valid_d ? ptr_d : '0;
        rpt_last_d  = rpt_valid_d && (ptr_d == c_last_ptr);
`ifdef STATS_SCHED_SEQNUM_EN
        if (rpt_valid_d && hdr_d) begin
            rpt_data_d = seq_d;
            rpt_idx_d  = c_hdr_idx;
            rpt_last_d = 1'b0;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge asclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            snap_q      <= '0;
            ovr_q       <= '0;
            rpt_valid_q <= 1'b0;
            rpt_data_q  <= '0;
            rpt_idx_q   <= '0;
            rpt_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef STATS_SCHED_SEQNUM_EN
            seq_q       <= '0;
            hdr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            snap_q      <= snap_d;
            ovr_q       <= ovr_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_data_q  <= rpt_data_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_last_q  <= rpt_last_d;
            busy_q      <= busy_d;
`ifdef STATS_SCHED_SEQNUM_EN
            seq_q       <= seq_d;
            hdr_q       <= hdr_d;
`endif
        end
    end

    assign rpt_valid   = rpt_valid_q;
    assign rpt_data    = rpt_data_q;
    assign rpt_idx     = rpt_idx_q;
    assign rpt_last    = rpt_last_q;
    assign overrun_cnt = ovr_q;
    assign busy        = busy_q;

endmodule : stats_epoch_sched
`default_nettype wire

// File: tb/tb_stats_epoch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stats_epoch_sched
// Description : Directed testbench for stats_epoch_sched with EPOCH_TICKS=20
//               and NUM_FEAT=4. Optional header behaviour follows
//               STATS_SCHED_SEQNUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stats_epoch_sched;

    logic          asclk = 1'b0;
    logic          aresetn;
    logic          sched_en;
    logic [127:0]  feat_val;
    logic [27:0]   cnt_time;
    logic          epoch_tick;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [31:0]   rpt_data;
    logic [7:0]    rpt_idx;
    logic          rpt_last;
    logic [15:0]   overrun_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    stats_epoch_sched #(
        .EPOCH_TICKS (20),
        .NUM_FEAT    (4)
    ) dut (
        .asclk       (asclk),
        .aresetn     (aresetn),
        .sched_en    (sched_en),
        .feat_val    (feat_val),
        .cnt_time    (cnt_time),
        .epoch_tick  (epoch_tick),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_data    (rpt_data),
        .rpt_idx     (rpt_idx),
        .rpt_last    (rpt_last),
        .overrun_cnt (overrun_cnt),
        .busy        (busy)
    );

    always #5 asclk = ~asclk;

    // Bounded waits; an expired bound counts as a failed comparison.
    task automatic wait_tick(input string who);
        int n = 0;
        while (epoch_tick !== 1'b1 && n < 60) begin
            @(negedge asclk);
            n++;
        end
        total++;
        if (epoch_tick !== 1'b1) begin
            bad++;
            $display("FAIL %s: timeout waiting epoch_tick, got %b want 1", who, epoch_tick);
        end
    endtask

    task automatic wait_valid(input string who);
        int n = 0;
        while (rpt_valid !== 1'b1 && n < 60) begin
            @(negedge asclk);
            n++;
        end
        total++;
        if (rpt_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: timeout waiting rpt_valid, got %b want 1", who, rpt_valid);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({cnt_time, epoch_tick, rpt_valid, rpt_data, rpt_idx, rpt_last, overrun_cnt, busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: cnt=%0d tick=%b v=%b d=%0h i=%0h l=%b ovr=%0d busy=%b, want all 0",
                     cnt_time, epoch_tick, rpt_valid, rpt_data, rpt_idx, rpt_last, overrun_cnt, busy);
        end
    endtask

    task automatic test_epoch_report();
        wait_tick("first_tick");
        total++;
        if (cnt_time !== 28'd20) begin
            bad++; $display("FAIL tick_cnt: got %0d want 20", cnt_time);
        end
        @(negedge asclk);
        total++;
        if (cnt_time !== 28'd0 || epoch_tick !== 1'b0) begin
            bad++; $display("FAIL wrap: cnt=%0d tick=%b want 0/0", cnt_time, epoch_tick);
        end
        wait_valid("first_report");
`ifdef STATS_SCHED_SEQNUM_EN
        total++;
        if (rpt_idx !== 8'hFF || rpt_data !== 32'd1 || rpt_last !== 1'b0) begin
            bad++; $display("FAIL hdr1: idx=%0h data=%0d last=%b want ff/1/0", rpt_idx, rpt_data, rpt_last);
        end
        @(negedge asclk);
`endif
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rpt_valid !== 1'b1 || rpt_idx !== 8'(k) || rpt_data !== 32'(k + 1) || rpt_last !== (k == 3)) begin
                bad++;
                $display("FAIL rec%0d: v=%b idx=%0d data=%0d last=%b want 1/%0d/%0d/%b",
                         k, rpt_valid, rpt_idx, rpt_data, rpt_last, k, k + 1, (k == 3));
            end
            @(negedge asclk);
        end
        total++;
        if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL report_end: v=%b busy=%b want 0/0", rpt_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        wait_valid("bp_report");
`ifdef STATS_SCHED_SEQNUM_EN
        total++;
        if (rpt_idx !== 8'hFF || rpt_data !== 32'd2) begin
            bad++; $display("FAIL hdr2: idx=%0h data=%0d want ff/2", rpt_idx, rpt_data);
        end
        @(negedge asclk);
`endif
        @(negedge asclk);
        rpt_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rpt_valid !== 1'b1 || rpt_idx !== 8'd1 || rpt_data !== 32'd2) begin
                bad++; $display("FAIL stall%0d: v=%b idx=%0d data=%0d want 1/1/2", c, rpt_valid, rpt_idx, rpt_data);
            end
            @(negedge asclk);
        end
        rpt_ready = 1'b1;
        @(negedge asclk);
        total++;
        if (rpt_idx !== 8'd2 || rpt_data !== 32'd3 || rpt_last !== 1'b0) begin
            bad++; $display("FAIL bp_idx2: idx=%0d data=%0d last=%b want 2/3/0", rpt_idx, rpt_data, rpt_last);
        end
        @(negedge asclk);
        total++;
        if (rpt_idx !== 8'd3 || rpt_data !== 32'd4 || rpt_last !== 1'b1) begin
            bad++; $display("FAIL bp_idx3: idx=%0d data=%0d last=%b want 3/4/1", rpt_idx, rpt_data, rpt_last);
        end
        @(negedge asclk);
        total++;
        if (rpt_valid !== 1'b0) begin
            bad++; $display("FAIL bp_done: v=%b want 0", rpt_valid);
        end
    endtask

    task automatic test_overrun();
        rpt_ready = 1'b0;
        wait_valid("ovr_report");
        feat_val = {32'd8, 32'd7, 32'd6, 32'd5};
        wait_tick("ovr_tick");
        total++;
        if (overrun_cnt !== 16'd0 || rpt_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_before: ovr=%0d v=%b want 0/1", overrun_cnt, rpt_valid);
        end
        @(negedge asclk);
        total++;
        if (overrun_cnt !== 16'd1 || rpt_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL ovr_after: ovr=%0d v=%b busy=%b want 1/0/1", overrun_cnt, rpt_valid, busy);
        end
        @(negedge asclk);
`ifdef STATS_SCHED_SEQNUM_EN
        total++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 8'hFF) begin
            bad++; $display("FAIL ovr_hdr: v=%b idx=%0h want 1/ff", rpt_valid, rpt_idx);
        end
        rpt_ready = 1'b1;
        @(negedge asclk);
`endif
        total++;
        if (rpt_valid !== 1'b1 || rpt_idx !== 8'd0 || rpt_data !== 32'd5) begin
            bad++; $display("FAIL ovr_restart: v=%b idx=%0d data=%0d want 1/0/5", rpt_valid, rpt_idx, rpt_data);
        end
        rpt_ready = 1'b1;
        @(negedge asclk);
        total++;
        if (rpt_idx !== 8'd1 || rpt_data !== 32'd6) begin
            bad++; $display("FAIL ovr_idx1: idx=%0d data=%0d want 1/6", rpt_idx, rpt_data);
        end
        for (int n = 0; n < 10 && rpt_valid === 1'b1; n++) @(negedge asclk);
        total++;
        if (rpt_valid !== 1'b0 || overrun_cnt !== 16'd1) begin
            bad++; $display("FAIL ovr_drain: v=%b ovr=%0d want 0/1", rpt_valid, overrun_cnt);
        end
    endtask

    task automatic test_hold();
        int n = 0;
        while (cnt_time !== 28'd7 && n < 60) begin
            @(negedge asclk);
            n++;
        end
        sched_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge asclk);
            total++;
            if (cnt_time !== 28'd7 || epoch_tick !== 1'b0) begin
                bad++; $display("FAIL hold%0d: cnt=%0d tick=%b want 7/0", c, cnt_time, epoch_tick);
            end
        end
        sched_en = 1'b1;
    endtask

    task automatic test_reset_mid_send();
        wait_valid("rst_report");
`ifdef STATS_SCHED_SEQNUM_EN
        @(negedge asclk);
`endif
        @(negedge asclk);
        @(negedge asclk);
        total++;
        if (rpt_idx !== 8'd2 || rpt_valid !== 1'b1) begin
            bad++; $display("FAIL rst_pre: idx=%0d v=%b want 2/1", rpt_idx, rpt_valid);
        end
        #1 aresetn = 1'b0;
        #1;
        total++;
        if (rpt_valid !== 1'b0 || overrun_cnt !== 16'd0 || busy !== 1'b0 || cnt_time !== 28'd0 || rpt_idx !== 8'd0) begin
            bad++; $display("FAIL rst_async: v=%b ovr=%0d busy=%b cnt=%0d idx=%0d want 0/0/0/0/0",
                            rpt_valid, overrun_cnt, busy, cnt_time, rpt_idx);
        end
        @(negedge asclk);
        aresetn = 1'b1;
        repeat (5) @(negedge asclk);
        total++;
        if (rpt_valid !== 1'b0 || busy !== 1'b0 || cnt_time !== 28'd5) begin
            bad++; $display("FAIL rst_noresume: v=%b busy=%b cnt=%0d want 0/0/5", rpt_valid, busy, cnt_time);
        end
    endtask

`ifdef STATS_SCHED_SEQNUM_EN
    task automatic test_seqnum();
        wait_valid("seq_first");
        total++;
        if (rpt_idx !== 8'hFF || rpt_data !== 32'd1 || rpt_last !== 1'b0) begin
            bad++; $display("FAIL seq1: idx=%0h data=%0d last=%b want ff/1/0", rpt_idx, rpt_data, rpt_last);
        end
        for (int n = 0; n < 10 && rpt_valid === 1'b1; n++) @(negedge asclk);
        wait_valid("seq_second");
        total++;
        if (rpt_idx !== 8'hFF || rpt_data !== 32'd2) begin
            bad++; $display("FAIL seq2: idx=%0h data=%0d want ff/2", rpt_idx, rpt_data);
        end
    endtask
`endif

    initial begin
        aresetn   = 1'b0;
        sched_en  = 1'b0;
        rpt_ready = 1'b0;
        feat_val  = {32'd4, 32'd3, 32'd2, 32'd1};
        repeat (3) @(negedge asclk);
        test_reset();
        aresetn   = 1'b1;
        sched_en  = 1'b1;
        rpt_ready = 1'b1;
        test_epoch_report();
        test_backpressure();
        test_overrun();
        test_hold();
        test_reset_mid_send();
`ifdef STATS_SCHED_SEQNUM_EN
        test_seqnum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stats_epoch_sched
`default_nettype wire
